// File: rtl/sync_debounce_bank.sv
// sync_debounce_bank: per-channel synchronizer with edge pulses; debounce filter built when SYNC_BANK_DEBOUNCE_EN is defined
module sync_debounce_bank #(
    parameter int WIDTH      = 4,
    parameter int STAGES     = 2,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] indata,
    output logic [WIDTH-1:0] outdata,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    if (WIDTH < 1 || STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_params
        $error("sync_debounce_bank: illegal parameter values");
    end

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] prev_q, prev_d;

    // plain shift chain: stage 0 captures the raw level, no logic between flops
    always_comb begin
        sync_d[0] = indata;
        for (int s = 1; s < STAGES; s++) sync_d[s] = sync_q[s-1];
    end

    // synchronizer flops
    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES; s++) sync_q[s] <= reset ? '0 : sync_d[s];
    end

    assign synced = sync_q[STAGES-1];

`ifdef SYNC_BANK_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] out_q, out_d;

    // count cycles of disagreement; accept the new level on the DEB_CYCLES-th one
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != out_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) out_d[i] = synced[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // debounced level and per-channel counters
    always_ff @(posedge clk) begin
        out_q <= reset ? '0 : out_d;
        for (int i = 0; i < WIDTH; i++) cnt_q[i] <= reset ? '0 : cnt_d[i];
    end

    assign outdata = out_q;
`else
    assign outdata = synced;
`endif

    assign prev_d = outdata;

    // registered copy of outdata for edge detection
    always_ff @(posedge clk) begin
        prev_q <= reset ? '0 : prev_d;
    end

    // pulses on the first cycle of a new level, suppressed while reset is asserted
    always_comb begin
        rise    = reset ? '0 : outdata & ~prev_q;
        fall    = reset ? '0 : ~outdata & prev_q;
        changed = |(rise | fall);
    end
endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb_sync_debounce_bank: directed and randomized checks of sync_debounce_bank against a sample-history reference model
module tb_sync_debounce_bank;
    localparam int W   = 4;
    localparam int STG = 2;
    localparam int DEB = 4;
`ifdef SYNC_BANK_DEBOUNCE_EN
    localparam int LAT = STG + DEB;
`else
    localparam int LAT = STG;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] indata = '0;
    logic [W-1:0] outdata, rise, fall;
    logic         changed;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] smp [$];
    logic [W-1:0] win [$];
    logic [W-1:0] m_out = '0, m_prev = '0, m_rise, m_fall;
    logic         m_chg;

    sync_debounce_bank #(.WIDTH(W), .STAGES(STG), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .indata(indata),
        .outdata(outdata), .rise(rise), .fall(fall), .changed(changed)
    );

    always #5 clk = ~clk;

    // advance one edge; model: synced is the sample from STAGES edges back,
    // a level is accepted once the last DEB synced values all disagree with it
    task automatic step();
        logic [W-1:0] pre;
        bit all;
        @(posedge clk);
        if (reset) begin
            smp = {};
            repeat (STG) smp.push_back('0);
            win = {};
            m_out = '0;
            m_prev = '0;
        end else begin
            pre = smp[0];
            void'(smp.pop_front());
            smp.push_back(indata);
            m_prev = m_out;
`ifdef SYNC_BANK_DEBOUNCE_EN
            win.push_back(pre);
            if (win.size() > DEB) void'(win.pop_front());
            if (win.size() == DEB)
                for (int b = 0; b < W; b++) begin
                    all = 1;
                    foreach (win[j]) if (win[j][b] == m_prev[b]) all = 0;
                    if (all) m_out[b] = ~m_prev[b];
                end
`else
            m_out = smp[0];
`endif
        end
        m_rise = m_out & ~m_prev;
        m_fall = ~m_out & m_prev;
        m_chg  = |(m_rise | m_fall);
        #1;
    endtask

    task automatic settle(input logic [W-1:0] v);
        indata = v;
        repeat (LAT + 3) step();
    endtask

    task automatic test_reset();
        logic [W-1:0] eo, er;
        reset = 1'b1;
        indata = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++; if (outdata !== 4'h0) begin n_bad++; $display("FAIL reset_out k=%0d got %h exp 0", k, outdata); end
            n_cmp++; if ({rise, fall, changed} !== 9'd0) begin n_bad++; $display("FAIL reset_pulse k=%0d got %h/%h/%b exp 0", k, rise, fall, changed); end
        end
        reset = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            step();
            eo = (k >= LAT) ? 4'hF : 4'h0;
            er = (k == LAT) ? 4'hF : 4'h0;
            n_cmp++; if (outdata !== eo) begin n_bad++; $display("FAIL release_out k=%0d got %h exp %h", k, outdata, eo); end
            n_cmp++; if (rise !== er || fall !== 4'h0) begin n_bad++; $display("FAIL release_rise k=%0d got %h/%h exp %h/0", k, rise, fall, er); end
            n_cmp++; if (changed !== (k == LAT)) begin n_bad++; $display("FAIL release_changed k=%0d got %b exp %b", k, changed, k == LAT); end
        end
    endtask

    task automatic test_glitch();
        settle(4'h0);
        for (int k = 1; k <= LAT + 6; k++) begin
            indata = (k <= 3) ? 4'h1 : 4'h0;
            step();
            n_cmp++; if ({outdata, rise, fall, changed} !== {m_out, m_rise, m_fall, m_chg}) begin
                n_bad++; $display("FAIL glitch_model k=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", k, outdata, rise, fall, changed, m_out, m_rise, m_fall, m_chg);
            end
`ifdef SYNC_BANK_DEBOUNCE_EN
            n_cmp++; if (outdata[0] !== 1'b0 || rise[0] !== 1'b0 || changed !== 1'b0) begin
                n_bad++; $display("FAIL glitch_reject k=%0d got out=%b rise=%b chg=%b exp 0", k, outdata[0], rise[0], changed);
            end
`endif
        end
    endtask

    task automatic test_fall();
        logic [W-1:0] ef;
        settle(4'b0100);
        indata = 4'h0;
        for (int k = 1; k <= LAT + 3; k++) begin
            step();
            ef = (k == LAT) ? 4'b0100 : 4'h0;
            n_cmp++; if (outdata[2] !== (k < LAT)) begin n_bad++; $display("FAIL fall_out k=%0d got %b exp %b", k, outdata[2], k < LAT); end
            n_cmp++; if (fall !== ef || rise !== 4'h0) begin n_bad++; $display("FAIL fall_pulse k=%0d got %h/%h exp 0/%h", k, rise, fall, ef); end
        end
    endtask

    task automatic test_independence();
        logic [W-1:0] er;
        settle(4'h0);
        for (int k = 1; k <= LAT + 5; k++) begin
            indata = (k >= 3) ? 4'b1010 : 4'b0010;
            step();
            er = (k == LAT) ? 4'b0010 : (k == LAT + 2) ? 4'b1000 : 4'h0;
            n_cmp++; if (rise !== er || fall !== 4'h0) begin n_bad++; $display("FAIL indep_pulse k=%0d got %h/%h exp %h/0", k, rise, fall, er); end
            n_cmp++; if (changed !== (er != 4'h0)) begin n_bad++; $display("FAIL indep_changed k=%0d got %b exp %b", k, changed, er != 4'h0); end
        end
    endtask

    task automatic test_reset_mid();
        settle(4'h0);
        indata = 4'h1;
        repeat (5) step();
        reset = 1'b1;
        step();
        n_cmp++; if (outdata !== 4'h0 || changed !== 1'b0) begin n_bad++; $display("FAIL midreset_out got %h/%b exp 0/0", outdata, changed); end
        reset = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            n_cmp++; if (outdata[0] !== (k >= LAT)) begin n_bad++; $display("FAIL midreset_rel k=%0d got %b exp %b", k, outdata[0], k >= LAT); end
            n_cmp++; if (rise[0] !== (k == LAT)) begin n_bad++; $display("FAIL midreset_rise k=%0d got %b exp %b", k, rise[0], k == LAT); end
        end
    endtask

    task automatic test_pulse();
        logic eo, er, ef;
        settle(4'h0);
        for (int k = 1; k <= 6; k++) begin
            indata = (k == 1) ? 4'h1 : 4'h0;
            step();
`ifdef SYNC_BANK_DEBOUNCE_EN
            eo = 1'b0; er = 1'b0; ef = 1'b0;
`else
            eo = (k == 2); er = (k == 2); ef = (k == 3);
`endif
            n_cmp++; if (outdata[0] !== eo) begin n_bad++; $display("FAIL pulse_out k=%0d got %b exp %b", k, outdata[0], eo); end
            n_cmp++; if (rise[0] !== er || fall[0] !== ef) begin n_bad++; $display("FAIL pulse_edges k=%0d got %b/%b exp %b/%b", k, rise[0], fall[0], er, ef); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < W; b++) if ($urandom_range(5) == 0) indata[b] = ~indata[b];
            reset = ($urandom_range(149) == 0);
            step();
            n_cmp++; if (outdata !== m_out) begin n_bad++; $display("FAIL rand_out k=%0d got %h exp %h", k, outdata, m_out); end
            n_cmp++; if (rise !== m_rise || fall !== m_fall) begin n_bad++; $display("FAIL rand_edges k=%0d got %h/%h exp %h/%h", k, rise, fall, m_rise, m_fall); end
            n_cmp++; if (changed !== m_chg) begin n_bad++; $display("FAIL rand_changed k=%0d got %b exp %b", k, changed, m_chg); end
        end
        reset = 1'b0;
    endtask

    initial begin
        repeat (STG) smp.push_back('0);
        test_reset();
        test_glitch();
        test_fall();
        test_independence();
        test_reset_mid();
        test_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
